spi_slave_if: RTL

Serial front end of the SPI wrapper. It deserialises MOSI frames into 10-bit command words for the single-port RAM stage and serialises RAM read data back onto MISO. It sits directly upstream of the RAM: it drives `rx_data`/`rx_valid` into the RAM's `din`/`rx_valid`, and it consumes the RAM's `dout`/`tx_valid` as `tx_data`/`tx_valid`.

---
 rtl/spi_slave_if.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command frames from MOSI
// and serialises 8-bit read data back onto MISO.
module spi_slave_if (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       rd_addr_seen;
  logic [3:0] cnt;
  logic [8:0] shift;
  logic [7:0] tx_buf;
  logic       rx_done;
  logic       tx_busy;
  logic       tx_done;
  logic       shifting;
  logic       last_bit;
  logic       tx_start;
  logic       abort;

  assign abort = (state != IDLE) && SS_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    state_nxt = state;
    shifting  = 1'b0;
    tx_start  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!SS_n) state_nxt = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_seen) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD: begin
        if (SS_n) state_nxt = IDLE;
        else      shifting  = !rx_done;
      end
      READ_DATA: begin
        if (SS_n) begin
          state_nxt = IDLE;
        end else begin
          shifting = !rx_done;
          tx_start = rx_done && !tx_busy &&
                     !tx_done && tx_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
    last_bit = shifting && (cnt == 4'd8);
  end

  // Shift-in, command strobe and MISO shift-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_seen <= 1'b0;
      cnt          <= '0;
      shift        <= '0;
      tx_buf       <= '0;
      rx_done      <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        cnt     <= '0;
        MISO    <= 1'b0;
        rx_done <= 1'b0;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
      end else begin
        if (state == CHK_CMD) begin
          shift   <= {shift[7:0], MOSI};
          cnt     <= '0;
          rx_done <= 1'b0;
          tx_busy <= 1'b0;
          tx_done <= 1'b0;
        end
        if (shifting) begin
          shift <= {shift[7:0], MOSI};
          cnt   <= cnt + 4'd1;
          if (last_bit) begin
            rx_data  <= {shift, MOSI};
            rx_valid <= 1'b1;
            rx_done  <= 1'b1;
            cnt      <= '0;
            if (state == READ_ADD)
              rd_addr_seen <= 1'b1;
            else if (state == READ_DATA)
              rd_addr_seen <= 1'b0;
          end
        end
        if (tx_start) begin
          MISO    <= tx_data[7];
          tx_buf  <= {tx_data[6:0], 1'b0};
          tx_busy <= 1'b1;
          cnt     <= 4'd1;
        end else if (tx_busy) begin
          if (cnt == 4'd8) begin
            MISO    <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            cnt     <= '0;
          end else begin
            MISO   <= tx_buf[7];
            tx_buf <= {tx_buf[6:0], 1'b0};
            cnt    <= cnt + 4'd1;
          end
        end
      end
    end
  end

endmodule
